// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I register-file write-back path.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;
    logic [1:0]            addr_lo;
  } lq_entry_t;

endpackage

// File: rtl/rv32i_writeback_if.sv
// Bundle of ALU, load-issue, load-response and register-file write signals.
// RV32I_WB_FWD_EN adds the forwarding taps on the registered write.
interface rv32i_writeback_if #(parameter int XLEN = 32);

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            ld_issue;
  logic [4:0]      ld_issue_rd;
  logic [2:0]      ld_issue_funct3;
  logic [1:0]      ld_issue_addr_lo;
  logic            ld_issue_ready;

  logic            ld_resp_valid;
  logic [XLEN-1:0] ld_resp_data;

  logic            rf_write;
  logic [4:0]      rf_reg_w0;
  logic [XLEN-1:0] rf_in;
  logic [31:0]     busy_mask;
  logic            err_unexpected;

`ifdef RV32I_WB_FWD_EN
  logic [4:0]      fwd_rs0;
  logic [4:0]      fwd_rs1;
  logic            fwd_hit0;
  logic            fwd_hit1;
  logic [XLEN-1:0] fwd_data0;
  logic [XLEN-1:0] fwd_data1;
`endif

  // master is the write-back unit, slave is the pipeline / memory side
  modport master (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_issue_rd, ld_issue_funct3, ld_issue_addr_lo,
    input  ld_resp_valid, ld_resp_data,
`ifdef RV32I_WB_FWD_EN
    input  fwd_rs0, fwd_rs1,
    output fwd_hit0, fwd_hit1, fwd_data0, fwd_data1,
`endif
    output alu_ready, ld_issue_ready,
    output rf_write, rf_reg_w0, rf_in, busy_mask, err_unexpected
  );

  modport slave (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_issue_rd, ld_issue_funct3, ld_issue_addr_lo,
    output ld_resp_valid, ld_resp_data,
`ifdef RV32I_WB_FWD_EN
    output fwd_rs0, fwd_rs1,
    input  fwd_hit0, fwd_hit1, fwd_data0, fwd_data1,
`endif
    input  alu_ready, ld_issue_ready,
    input  rf_write, rf_reg_w0, rf_in, busy_mask, err_unexpected
  );

endinterface

// File: rtl/rv32i_wb_load_queue.sv
// In-order FIFO of outstanding load descriptors; head is the next response owner.
module rv32i_wb_load_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  lq_entry_t i_entry,
  input  logic      i_pop,
  output lq_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  lq_entry_t   r_mem [DEPTH];
  logic        w_push_ok;
  logic        w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
  end

endmodule

// File: rtl/rv32i_writeback.sv
// Register-file write master: merges ALU results and in-order load responses,
// extends loaded bytes/halves and tracks pending load destinations.
// Optional RV32I_WB_FWD_EN exposes the registered write for operand forwarding.
module rv32i_writeback #(
  parameter int LQ_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic               clk,
  input  logic               rst,
  rv32i_writeback_if.master  bus
);

  import rv32i_pkg::*;

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      f3,
                                                  input logic [1:0]      lo,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      LB:      load_extend = {{(XLEN-8){b[7]}}, b};
      LBU:     load_extend = {{(XLEN-8){1'b0}}, b};
      LH:      load_extend = {{(XLEN-16){h[15]}}, h};
      LHU:     load_extend = {{(XLEN-16){1'b0}}, h};
      default: load_extend = word;
    endcase
  endfunction

  logic            w_lq_full;
  logic            w_lq_empty;
  logic            w_issue_ok;
  logic            w_push;
  logic            w_pop;
  logic            w_alu_ok;
  logic            w_alu_accept;
  lq_entry_t       w_head;
  lq_entry_t       w_issue_entry;
  logic [31:0]     w_busy_next;

  logic [31:0]     r_busy;
  logic            r_rf_write;
  logic [4:0]      r_rf_reg_w0;
  logic [XLEN-1:0] r_rf_in;
  logic            r_err;

  assign w_issue_ok    = !w_lq_full && !(bus.ld_issue_rd != '0 && r_busy[bus.ld_issue_rd]);
  assign w_push        = bus.ld_issue && w_issue_ok;
  assign w_pop         = bus.ld_resp_valid && !w_lq_empty;
  assign w_alu_ok      = !bus.ld_resp_valid && !(bus.alu_rd != '0 && r_busy[bus.alu_rd]);
  assign w_alu_accept  = bus.alu_valid && w_alu_ok;
  assign w_issue_entry = '{rd: bus.ld_issue_rd, funct3: bus.ld_issue_funct3,
                           addr_lo: bus.ld_issue_addr_lo};

  rv32i_wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_issue_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_lq_full),
    .o_empty (w_lq_empty)
  );

  // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop)                             w_busy_next[w_head.rd] = 1'b0;
    if (w_push && bus.ld_issue_rd != '0)   w_busy_next[bus.ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= '0;
      r_rf_write  <= 1'b0;
      r_rf_reg_w0 <= '0;
      r_rf_in     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_busy     <= w_busy_next;
      r_rf_write <= 1'b0;
      // Load response wins the write port; x0 targets are consumed silently.
      if (w_pop) begin
        if (w_head.rd != '0) begin
          r_rf_write  <= 1'b1;
          r_rf_reg_w0 <= w_head.rd;
          r_rf_in     <= load_extend(w_head.funct3, w_head.addr_lo, bus.ld_resp_data);
        end
      end else if (w_alu_accept && bus.alu_rd != '0) begin
        r_rf_write  <= 1'b1;
        r_rf_reg_w0 <= bus.alu_rd;
        r_rf_in     <= bus.alu_data;
      end
      if (bus.ld_resp_valid && w_lq_empty) r_err <= 1'b1;
    end
  end

  assign bus.alu_ready      = w_alu_ok;
  assign bus.ld_issue_ready = w_issue_ok;
  assign bus.rf_write       = r_rf_write;
  assign bus.rf_reg_w0      = r_rf_reg_w0;
  assign bus.rf_in          = r_rf_in;
  assign bus.busy_mask      = r_busy;
  assign bus.err_unexpected = r_err;

`ifdef RV32I_WB_FWD_EN
  assign bus.fwd_hit0  = r_rf_write && (r_rf_reg_w0 == bus.fwd_rs0) && (bus.fwd_rs0 != '0);
  assign bus.fwd_hit1  = r_rf_write && (r_rf_reg_w0 == bus.fwd_rs1) && (bus.fwd_rs1 != '0);
  assign bus.fwd_data0 = r_rf_in;
  assign bus.fwd_data1 = r_rf_in;
`endif

endmodule

// File: tb/tb_rv32i_writeback.sv
// Self-checking bench for rv32i_writeback: vector table plus reset/unexpected-response sequence.
module tb_rv32i_writeback;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_writeback_if bus_if ();

  rv32i_writeback #(.LQ_DEPTH(2), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        iss;
    logic [4:0]  iss_rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        resp;
    logic [31:0] rdata;
    logic        e_ar;
    logic        e_ir;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_busy;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int alu_v, input int alu_rd, input logic [31:0] alu_data,
                              input int iss, input int iss_rd, input logic [2:0] f3, input int lo,
                              input int resp, input logic [31:0] rdata,
                              input int e_ar, input int e_ir,
                              input int e_wr, input int e_rd, input logic [31:0] e_data,
                              input logic [31:0] e_busy);
    vec_t v;
    v.alu_v = 1'(alu_v);  v.alu_rd = 5'(alu_rd); v.alu_data = alu_data;
    v.iss   = 1'(iss);    v.iss_rd = 5'(iss_rd); v.f3 = f3; v.lo = 2'(lo);
    v.resp  = 1'(resp);   v.rdata  = rdata;
    v.e_ar  = 1'(e_ar);   v.e_ir   = 1'(e_ir);
    v.e_wr  = 1'(e_wr);   v.e_rd   = 5'(e_rd);   v.e_data = e_data;
    v.e_busy = e_busy;
    return v;
  endfunction

  task automatic drive_idle();
    bus_if.alu_valid        = 1'b0;
    bus_if.alu_rd           = '0;
    bus_if.alu_data         = '0;
    bus_if.ld_issue         = 1'b0;
    bus_if.ld_issue_rd      = '0;
    bus_if.ld_issue_funct3  = '0;
    bus_if.ld_issue_addr_lo = '0;
    bus_if.ld_resp_valid    = 1'b0;
    bus_if.ld_resp_data     = '0;
`ifdef RV32I_WB_FWD_EN
    bus_if.fwd_rs0          = '0;
    bus_if.fwd_rs1          = '0;
`endif
  endtask

  task automatic apply(input vec_t v, input int idx);
    wr_t w;
    @(negedge clk);
    bus_if.alu_valid        = v.alu_v;
    bus_if.alu_rd           = v.alu_rd;
    bus_if.alu_data         = v.alu_data;
    bus_if.ld_issue         = v.iss;
    bus_if.ld_issue_rd      = v.iss_rd;
    bus_if.ld_issue_funct3  = v.f3;
    bus_if.ld_issue_addr_lo = v.lo;
    bus_if.ld_resp_valid    = v.resp;
    bus_if.ld_resp_data     = v.rdata;
`ifdef RV32I_WB_FWD_EN
    bus_if.fwd_rs0          = v.e_rd;
    bus_if.fwd_rs1          = '0;
`endif
    #1;
    check($sformatf("v%0d alu_ready", idx), bus_if.alu_ready, v.e_ar);
    check($sformatf("v%0d ld_issue_ready", idx), bus_if.ld_issue_ready, v.e_ir);
    if (v.e_wr) sb.push_back('{rd: v.e_rd, data: v.e_data});
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      w = sb.pop_front();
      check($sformatf("v%0d rf_write", idx), bus_if.rf_write, 1'b1);
      check($sformatf("v%0d rf_reg_w0", idx), bus_if.rf_reg_w0, w.rd);
      check($sformatf("v%0d rf_in", idx), bus_if.rf_in, w.data);
    end else begin
      check($sformatf("v%0d rf_write idle", idx), bus_if.rf_write, 1'b0);
    end
    check($sformatf("v%0d busy_mask", idx), bus_if.busy_mask, v.e_busy);
`ifdef RV32I_WB_FWD_EN
    check($sformatf("v%0d fwd_hit0", idx), bus_if.fwd_hit0, v.e_wr);
    check($sformatf("v%0d fwd_hit1", idx), bus_if.fwd_hit1, 1'b0);
    if (v.e_wr) check($sformatf("v%0d fwd_data0", idx), bus_if.fwd_data0, v.e_data);
`endif
  endtask

  initial begin
    drive_idle();

    //        alu_v rd data          iss rd f3    lo resp rdata          ar ir wr rd data           busy
    vecs.push_back(mk(1, 5, 32'h1234,      0, 0, LB,   0, 0, 32'h0,         1, 1, 1, 5, 32'h0000_1234, 32'h0));
    vecs.push_back(mk(1, 0, 32'hFFFF,      0, 0, LB,   0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 7, LB,   3, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h80));
    vecs.push_back(mk(0, 7, 32'h0,         0, 7, LB,   0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h80));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, LB,   0, 1, 32'h80FF_0000, 0, 1, 1, 7, 32'hFFFF_FF80, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 8, LHU,  2, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h100));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, LB,   0, 1, 32'h80FF_0000, 0, 1, 1, 8, 32'h0000_80FF, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 9, LW,   0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h200));
    vecs.push_back(mk(1, 3, 32'h55,        0, 0, LB,   0, 1, 32'hDEAD_BEEF, 0, 1, 1, 9, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(1, 3, 32'h55,        0, 0, LB,   0, 0, 32'h0,         1, 1, 1, 3, 32'h0000_0055, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 1, LH,   2, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h2));
    vecs.push_back(mk(0, 0, 32'h0,         1, 2, LBU,  1, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h6));
    vecs.push_back(mk(1, 2, 32'h77,        1, 3, LW,   0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h6));
    vecs.push_back(mk(0, 0, 32'h0,         1, 4, LW,   0, 1, 32'h8001_7F00, 0, 0, 1, 1, 32'hFFFF_8001, 32'h4));
    vecs.push_back(mk(0, 0, 32'h0,         1, 2, LW,   0, 0, 32'h0,         1, 0, 0, 0, 32'h0,         32'h4));
    vecs.push_back(mk(0, 0, 32'h0,         1, 6, LB,   2, 1, 32'h0000_F500, 0, 1, 1, 2, 32'h0000_00F5, 32'h40));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, LB,   0, 1, 32'h007F_0000, 0, 1, 1, 6, 32'h0000_007F, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 10, 3'b111, 1, 0, 32'h0,      1, 1, 0, 0, 32'h0,         32'h400));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, LB,   0, 1, 32'h1234_5678, 0, 1, 1, 10, 32'h1234_5678, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, LW,   0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, LB,   0, 1, 32'h0000_AAAA, 0, 1, 0, 0, 32'h0,         32'h0));

    repeat (2) @(posedge clk);
    #1;
    check("reset rf_write", bus_if.rf_write, 1'b0);
    check("reset rf_reg_w0", bus_if.rf_reg_w0, 5'd0);
    check("reset rf_in", bus_if.rf_in, 32'h0);
    check("reset busy_mask", bus_if.busy_mask, 32'h0);
    check("reset err_unexpected", bus_if.err_unexpected, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    check("no spurious err", bus_if.err_unexpected, 1'b0);

    // Asynchronous reset mid-load with a write on the port.
    @(negedge clk);
    drive_idle();
    bus_if.alu_valid        = 1'b1;
    bus_if.alu_rd           = 5'd12;
    bus_if.alu_data         = 32'h99;
    bus_if.ld_issue         = 1'b1;
    bus_if.ld_issue_rd      = 5'd11;
    bus_if.ld_issue_funct3  = LW;
    @(posedge clk);
    #1;
    check("pre-rst rf_write", bus_if.rf_write, 1'b1);
    check("pre-rst busy_mask", bus_if.busy_mask, 32'h800);
    #2;
    rst = 1'b1;
    #1;
    check("async rst rf_write", bus_if.rf_write, 1'b0);
    check("async rst rf_reg_w0", bus_if.rf_reg_w0, 5'd0);
    check("async rst rf_in", bus_if.rf_in, 32'h0);
    check("async rst busy_mask", bus_if.busy_mask, 32'h0);
    check("async rst err", bus_if.err_unexpected, 1'b0);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;

    // Response for the load lost in reset must be flagged, not written.
    @(negedge clk);
    bus_if.ld_resp_valid = 1'b1;
    bus_if.ld_resp_data  = 32'h1111_2222;
    @(posedge clk);
    #1;
    check("unexpected err set", bus_if.err_unexpected, 1'b1);
    check("unexpected no write", bus_if.rf_write, 1'b0);
    @(negedge clk);
    bus_if.ld_resp_valid = 1'b0;
    @(posedge clk);
    #1;
    check("unexpected err sticky", bus_if.err_unexpected, 1'b1);
    check("unexpected idle write", bus_if.rf_write, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_writeback.md
Name: rv32i_writeback

Overview:
- Write-side master for the general-purpose register file.
- Merges single-cycle ALU results and out-of-order-in-time (but in-order) load responses onto the file's single write port.
- Applies RV32I load byte/half extension.
- Tracks pending-load destinations in a scoreboard so the decode stage can stall RAW/WAW hazards.

Parameters:
- LQ_DEPTH, 2, number of outstanding loads tracked (power of two, ≥2).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result present.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- ld_issue  in  1  load issued to memory.
- ld_issue_rd  in  5  load destination.
- ld_issue_funct3  in  3  load type.
- ld_issue_addr_lo  in  2  byte address bits [1:0].
- ld_issue_ready  out  1  issue accepted.
- ld_resp_valid  in  1  memory word returned (cannot be stalled).
- ld_resp_data  in  XLEN  raw aligned word.
- rf_write  out  1  register file write enable.
- rf_reg_w0  out  5  register file write index.
- rf_in  out  XLEN  register file write data.
- busy_mask  out  32  bit n set = load to xn pending.
- err_unexpected  out  1  sticky: response arrived with queue empty.

Behaviour:
- Reset (async, any cycle, including mid-operation): rf_write=0, rf_reg_w0=0, rf_in=0, busy_mask=0, err_unexpected=0, load queue emptied. In-flight responses after reset deassertion are treated as unexpected.
- Write outputs are registered. A result accepted in cycle N drives rf_write/rf_reg_w0/rf_in during cycle N+1, so it lands in the file at the end of N+1.
- Arbitration: a load response has absolute priority.
  - alu_ready = !ld_resp_valid && !(alu_rd!=0 && busy_mask[alu_rd]).
  - A rejected ALU result must be held stable by the producer.
- rd==0: the result is consumed (ready asserted normally) but rf_write stays 0; x0 is never written.
- Load queue: FIFO of {rd, funct3, addr_lo}.
  - ld_issue_ready = !full && !(ld_issue_rd!=0 && busy_mask[ld_issue_rd]). This is combinational on the inputs.
  - Issue pushes; a response pops the head.
- Simultaneous push and pop when full: the pop frees a slot, but ready still reflects pre-pop full, so the issue is rejected.
- busy_mask:
  - bit set on an accepted issue with rd!=0.
  - bit cleared on the response pop for that rd.
  - set and clear of different bits in the same cycle both take effect.
- Extension (shift = addr_lo*8):
  - LB: sign-extend byte [shift+7:shift].
  - LBU: zero-extend that byte.
  - LH: sign-extend half selected by addr_lo[1].
  - LHU: zero-extend that half.
  - LW: whole word.
  - Other funct3 values are written as LW.
  - Misalignment is not checked.
- ld_resp_valid with the queue empty: no write, err_unexpected set and held until rst.
- Steady state: no accepted source → rf_write=0; rf_reg_w0/rf_in hold their last value.

Optional Feature:
- Macro RV32I_WB_FWD_EN.
- Defined: adds inputs fwd_rs0, fwd_rs1 (5 each) and outputs fwd_hit0, fwd_hit1 (1 each), fwd_data0, fwd_data1 (XLEN each).
  - fwd_hitK = rf_write && rf_reg_w0==fwd_rsK && fwd_rsK!=0.
  - fwd_dataK = rf_in.
  - This covers the registered write not yet visible in the file.
- Undefined: these ports do not exist. The decoder must stall one extra cycle after a dependent write.

Decomposition:
- Package rv32i_pkg:
  - XLEN, REG_ADDR_W=5.
  - Load funct3 constants: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Queue entry struct/typedef {rd, funct3, addr_lo}.
- Sub-module rv32i_wb_load_queue: parameterised FIFO with full/empty, push/pop, head outputs.
- Extension logic stays inline as a combinational function.

Test Plan:
- ALU alone: alu_valid, rd=5, data=0x1234 → next cycle rf_write=1, rf_reg_w0=5, rf_in=0x1234; alu_ready=1.
- ALU to x0: alu_valid, rd=0, data=0xFFFF → alu_ready=1, rf_write stays 0.
- Load LB: issue rd=7, funct3=000, addr_lo=3; response 0x80FF_0000 → busy_mask[7]=1 until response; rf_in=0xFFFF_FF80, then busy_mask[7]=0. LHU, addr_lo=2, same word → rf_in=0x0000_80FF.
- Collision: ld_resp_valid and alu_valid in the same cycle → load written first, alu_ready=0. ALU held → written the following cycle.
- Queue full/hazard:
  - Two loads to rd=1, rd=2 outstanding, third issue → ld_issue_ready=0.
  - Issue to busy rd=1 with queue not full → ld_issue_ready=0.
  - alu_rd=2 while pending → alu_ready=0.
- Reset/unexpected:
  - Assert rst mid-load (busy_mask≠0) → all outputs 0 immediately, without a clock edge.
  - Response after reset → err_unexpected=1, rf_write=0.
